demux1to2_pipe: RTL and testbench
=================================

Name: demux1to2_pipe

Overview:
- Registered 1-to-2 demultiplexer: steers one W-bit word stream to one of two destinations, selected per word.
- It is the fan-out counterpart of the datapath 2:1 select muxes.
- Sits after the execute stage and routes results to either the register-file write-back path (port 0) or the store/memory path (port 1).
- Valid/ready handshake on every side; one-entry holding slot per output for full throughput.

Parameters:
- W, 32, data word width; shared with the 32-bit datapath.
- CNT_W, 16, statistics counter width (used only with DEMUX_STATS_EN).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  W  word to route.
- in_sel  input  1  destination: 0 -> port 0, 1 -> port 1.
- in_valid  input  1  in_data/in_sel valid.
- in_ready  output  1  block accepts this cycle.
- y0_data  output  W  port 0 data.
- y0_valid  output  1  port 0 slot holds a word.
- y0_ready  input  1  port 0 consumer accepts.
- y1_data  output  W  port 1 data.
- y1_valid  output  1  port 1 slot holds a word.
- y1_ready  input  1  port 1 consumer accepts.
- cnt0, cnt1, stall_cnt  output  CNT_W each  statistics; present only with DEMUX_STATS_EN.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst). While rst=1, y0_valid=y1_valid=0, y0_data=y1_data=0 and in_ready=0. Any held word is discarded, including on reset mid-transfer.
- Slots: each output slot is a 2-state FSM, EMPTY/FULL.
- in_ready (combinational): !rst && (slot[in_sel]==EMPTY || yN_ready for N=in_sel). It depends only on the selected slot; the other slot never blocks.
- Accept: accept = in_valid && in_ready. On accept, slot[in_sel] loads in_data and goes FULL. The word is visible on yN_data/yN_valid the next cycle, so latency is 1 cycle.
- Drain: yN_valid && yN_ready means the word is consumed. A FULL slot with drain and no load goes to EMPTY; yN_data holds its last value (not cleared).
- Simultaneous drain and load on the same slot: the slot stays FULL with the new word. Sustained throughput is 1 word/cycle per port.
- Blocked slot: a FULL slot whose consumer is not ready blocks only inputs selecting that port. While blocked, yN_data/yN_valid stay stable (AXI-style: no retraction or change while valid && !ready).
- Input side: the producer keeps in_data/in_sel stable while in_valid && !in_ready. The block does not check this.
- Ordering: words to the same port emerge in acceptance order. No cross-port ordering guarantee.
- in_sel is sampled only on accept. in_sel changing while in_valid is low has no effect.

Optional Feature:
- Macro DEMUX_STATS_EN.
- Defined: cnt0/cnt1 increment on each accept to port 0/1. stall_cnt increments each cycle with in_valid && !in_ready. All three saturate at 2^CNT_W-1 and clear on rst.
- Undefined: counter ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg:
  - parameter W=32 (replaces the file-level W);
  - typedef logic [W-1:0] word_t;
  - enum logic {DST_WB=1'b0, DST_MEM=1'b1} dst_e, used for in_sel;
  - enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_e.
- Sub-module demux_out_slot: one-entry FIFO slot with load/drain FSM, instantiated twice. Top level holds in_ready logic, load steering and the optional counters.

Test Plan:
- Reset: rst=1 for 3 cycles with in_valid=1 -> in_ready=0, y0_valid=y1_valid=0, y0_data=y1_data=0. After release, the first accept appears on the next cycle.
- Streaming: y0_ready=1 held, send 0x11111111, 0x22222222, 0x33333333 with in_sel=0 on consecutive cycles -> y0 emits the same words on consecutive cycles starting 1 cycle later; y1_valid stays 0.
- Independent backpressure: y0_ready=0, slot 0 FULL with 0xDEADBEEF, then send 0xCAFEF00D with in_sel=1 -> in_ready=1 and y1 shows 0xCAFEF00D next cycle. A following in_sel=0 word -> in_ready=0 until y0_ready rises; y0_data stays 0xDEADBEEF throughout.
- Simultaneous drain and load: slot 1 FULL with 0xA5A5A5A5, y1_ready=1, accept 0x5A5A5A5A to port 1 in the same cycle -> next cycle y1_valid=1, y1_data=0x5A5A5A5A, no bubble.
- Reset mid-operation: both slots FULL and stalled, assert rst for 1 cycle -> both valids 0 the next cycle; old words are never emitted.
- DEMUX_STATS_EN: 5 accepts to port 0, 3 to port 1, 4 stalled cycles -> cnt0=5, cnt1=3, stall_cnt=4. Build with CNT_W=4 and force 20 stalls -> stall_cnt=15 (saturated).

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared datapath types for the execute-stage fan-out logic.
// Holds the word width, the destination select encoding and the
// output-slot state encoding used by demux1to2_pipe and demux_out_slot.
package cpu_pkg;

  localparam int unsigned W = 32;

  typedef logic [W-1:0] word_t;

  // Destination of a routed result: register-file write-back or store path.
  typedef enum logic {
    DST_WB  = 1'b0,
    DST_MEM = 1'b1
  } dst_e;

  // Occupancy of a one-entry output slot.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry holding slot for one demux output port.
// A load while the slot drains keeps it FULL with the new word, so a port
// can sustain one word per cycle. The data register is not cleared on drain;
// it only changes on a load or on reset.
module demux_out_slot
  import cpu_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load_i,
  input  word_t load_data_i,
  input  logic  ready_i,
  output logic  valid_o,
  output word_t data_o,
  output logic  can_load_o
);

  slot_state_e state_q, state_d;
  word_t       data_q,  data_d;

  // Next-state and next-data for the slot: load wins, otherwise drain empties.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      SLOT_EMPTY: begin
        if (load_i) begin
          state_d = SLOT_FULL;
          data_d  = load_data_i;
        end else begin
          state_d = SLOT_EMPTY;
        end
      end
      SLOT_FULL: begin
        if (load_i) begin
          state_d = SLOT_FULL;
          data_d  = load_data_i;
        end else if (ready_i) begin
          state_d = SLOT_EMPTY;
        end else begin
          state_d = SLOT_FULL;
        end
      end
      default: begin
        state_d = SLOT_EMPTY;
      end
    endcase
  end

  // Slot state and data registers with synchronous reset discarding any word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid_o    = (state_q == SLOT_FULL);
  assign data_o     = data_q;
  // A new word fits if the slot is empty or its current word leaves this cycle.
  assign can_load_o = (state_q == SLOT_EMPTY) || ready_i;

endmodule

// File: rtl/demux1to2_pipe.sv
// Registered 1-to-2 demultiplexer between execute and the write-back /
// store paths. Each output owns a one-entry slot, so a stalled port only
// blocks words that select it.
// Optional build macro: DEMUX_STATS_EN adds saturating accept/stall counters
// (cnt0, cnt1, stall_cnt) of width CNT_W.
module demux1to2_pipe
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W = 16
)
(
  input  logic             clk,
  input  logic             rst,
  input  word_t            in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output word_t            y0_data,
  output logic             y0_valid,
  input  logic             y0_ready,
  output word_t            y1_data,
  output logic             y1_valid,
  input  logic             y1_ready
`ifdef DEMUX_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  dst_e dst_s;
  logic can_load0_s;
  logic can_load1_s;
  logic accept_s;
  logic load0_s;
  logic load1_s;

  assign dst_s    = dst_e'(in_sel);
  // Only the selected slot decides readiness; the other port never blocks.
  assign in_ready = !rst && ((dst_s == DST_MEM) ? can_load1_s : can_load0_s);
  assign accept_s = in_valid && in_ready;
  assign load0_s  = accept_s && (dst_s == DST_WB);
  assign load1_s  = accept_s && (dst_s == DST_MEM);

  demux_out_slot u_slot0 (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load0_s),
    .load_data_i (in_data),
    .ready_i     (y0_ready),
    .valid_o     (y0_valid),
    .data_o      (y0_data),
    .can_load_o  (can_load0_s)
  );

  demux_out_slot u_slot1 (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load1_s),
    .load_data_i (in_data),
    .ready_i     (y1_ready),
    .valid_o     (y1_valid),
    .data_o      (y1_data),
    .can_load_o  (can_load1_s)
  );

`ifdef DEMUX_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt0_q, cnt1_q, stall_q;
  logic             stall_s;

  assign stall_s = in_valid && !in_ready;

  // Saturating per-port accept counters and input stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      stall_q <= '0;
    end else begin
      if (load0_s && (cnt0_q != CNT_MAX)) begin
        cnt0_q <= cnt0_q + CNT_ONE;
      end
      if (load1_s && (cnt1_q != CNT_MAX)) begin
        cnt1_q <= cnt1_q + CNT_ONE;
      end
      if (stall_s && (stall_q != CNT_MAX)) begin
        stall_q <= stall_q + CNT_ONE;
      end
    end
  end

  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;
  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_demux1to2_pipe.sv
// Self-checking bench for demux1to2_pipe: directed scenarios followed by
// randomized traffic, all checked against a queue-based port model.
module tb_demux1to2_pipe;

  localparam int CNT_W = 4;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] y0_data;
  logic        y0_valid;
  logic        y0_ready;
  logic [31:0] y1_data;
  logic        y1_valid;
  logic        y1_ready;
`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic [CNT_W-1:0] stall_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: each port is a queue holding at most one word.
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] last0 = 32'h0;
  logic [31:0] last1 = 32'h0;
  logic        exp_rdy;
  int          m_cnt0 = 0;
  int          m_cnt1 = 0;
  int          m_stall = 0;
  int          cnt_max = (1 << CNT_W) - 1;

  demux1to2_pipe #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y0_data   (y0_data),
    .y0_valid  (y0_valid),
    .y0_ready  (y0_ready),
    .y1_data   (y1_data),
    .y1_valid  (y1_valid),
    .y1_ready  (y1_ready)
`ifdef DEMUX_STATS_EN
    ,
    .cnt0      (cnt0),
    .cnt1      (cnt1),
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic cycle(input logic v, input logic s, input logic [31:0] d,
                       input logic r0, input logic r1, input logic rs);
    logic acc;
    rst = rs; in_valid = v; in_sel = s; in_data = d; y0_ready = r0; y1_ready = r1;
    @(negedge clk);
    if (s) exp_rdy = !rs && (q1.size() == 0 || r1);
    else   exp_rdy = !rs && (q0.size() == 0 || r0);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("y0_valid", 32'(y0_valid), 32'(q0.size() != 0));
    chk("y1_valid", 32'(y1_valid), 32'(q1.size() != 0));
    chk("y0_data", y0_data, (q0.size() != 0) ? q0[0] : last0);
    chk("y1_data", y1_data, (q1.size() != 0) ? q1[0] : last1);
`ifdef DEMUX_STATS_EN
    chk("cnt0", 32'(cnt0), 32'(m_cnt0));
    chk("cnt1", 32'(cnt1), 32'(m_cnt1));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
    @(posedge clk);
    if (rs) begin
      q0.delete(); q1.delete();
      last0 = 32'h0; last1 = 32'h0;
      m_cnt0 = 0; m_cnt1 = 0; m_stall = 0;
    end else begin
      acc = v && exp_rdy;
      if (q0.size() != 0 && r0) void'(q0.pop_front());
      if (q1.size() != 0 && r1) void'(q1.pop_front());
      if (acc && !s) begin q0.push_back(d); last0 = d; if (m_cnt0 < cnt_max) m_cnt0++; end
      if (acc && s)  begin q1.push_back(d); last1 = d; if (m_cnt1 < cnt_max) m_cnt1++; end
      if (v && !exp_rdy && m_stall < cnt_max) m_stall++;
    end
    #1;
  endtask

  initial begin
    logic        hv, hs, hold;
    logic [31:0] hd;
    rst = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h0;
    y0_ready = 1'b0; y1_ready = 1'b0;
    @(posedge clk); #1;

    // Reset held 3 cycles with in_valid high.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h12345678, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0BADF00D, 1'b1, 1'b1, 1'b0);
    chk("first_accept_valid", 32'(y0_valid), 32'h1);
    chk("first_accept_data", y0_data, 32'h0BADF00D);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);

    // Streaming to port 0.
    cycle(1'b1, 1'b0, 32'h11111111, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'h22222222, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'h33333333, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Independent backpressure.
    cycle(1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0);
    chk("bp_port1_ready", 32'(exp_rdy), 32'h1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h01234567, 1'b0, 1'b0, 1'b0);
    chk("bp_hold_data", y0_data, 32'hDEADBEEF);
    chk("bp_port1_data", y1_data, 32'hCAFEF00D);
    cycle(1'b1, 1'b0, 32'h01234567, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);

    // Simultaneous drain and load on port 1.
    cycle(1'b1, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h5A5A5A5A, 1'b0, 1'b1, 1'b0);
    chk("sim_valid", 32'(y1_valid), 32'h1);
    chk("sim_data", y1_data, 32'h5A5A5A5A);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Reset with both slots full and stalled.
    cycle(1'b1, 1'b0, 32'hAAAA0000, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'hBBBB0000, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("rst_mid_v0", 32'(y0_valid), 32'h0);
    chk("rst_mid_v1", 32'(y1_valid), 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);

`ifdef DEMUX_STATS_EN
    // Counter scenario: 5 accepts to port 0, 3 to port 1, 4 stalls, then saturation.
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'(i + 100), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 32'(i + 200), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h77777777, 1'b0, 1'b1, 1'b0);
    chk("stats_cnt0", 32'(cnt0), 32'd5);
    chk("stats_cnt1", 32'(cnt1), 32'd3);
    chk("stats_stall", 32'(stall_cnt), 32'd4);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 32'h77777777, 1'b0, 1'b1, 1'b0);
    chk("stats_stall_sat", 32'(stall_cnt), 32'd15);
`endif

    // Randomized traffic with producer holding words while stalled.
    hold = 1'b0; hv = 1'b0; hs = 1'b0; hd = 32'h0;
    for (int i = 0; i < 400; i++) begin
      logic rs;
      rs = ($urandom_range(0, 49) == 0);
      if (!hold) begin
        hv = ($urandom_range(0, 3) != 0);
        hs = 1'($urandom_range(0, 1));
        hd = $urandom;
      end
      cycle(hv, hs, hd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rs);
      hold = hv && !exp_rdy && !rs;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
